// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers (shift-add multiply, restoring divide).
// Build option: define HILO_FAST_MUL_EN for a single-cycle array multiply; divide is unaffected.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mul,
    input  logic             div,
    input  logic             is_unsigned,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

`ifdef HILO_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               start_ok;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // mul and div together is not a valid start, so the unit stays idle and MT writes still apply.
    assign start_ok = (state_q == IDLE) && (mul ^ div);
    assign a_neg    = !is_unsigned && op_a[WIDTH-1];
    assign b_neg    = !is_unsigned && op_b[WIDTH-1];
    assign abs_a    = a_neg ? (~op_a + 1'b1) : op_a;
    assign abs_b    = b_neg ? (~op_b + 1'b1) : op_b;

    // Multiply: acc_lo holds the multiplier, shifted right as product bits enter from acc_hi.
    // Divide: acc_lo holds the dividend, shifted left as quotient bits enter at bit 0.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign prod      = {acc_hi_q, acc_lo_q};
    assign prod_fix  = neg_q ? (~prod + 1'b1) : prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            mcand_q    <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            mcand_q    <= mcand_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = (FAST_MUL && mul) ? FIX : RUN;
            RUN:     if (count_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        mcand_d    = mcand_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    count_d    = CW'(WIDTH - 1);
                    raw_a_d    = op_a;
                    is_div_d   = div;
                    neg_d      = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    div_zero_d = (op_b == '0);
                    acc_hi_d   = '0;
                    if (mul) begin
                        acc_lo_d = abs_b;
                        mcand_d  = abs_a;
`ifdef HILO_FAST_MUL_EN
                        {acc_hi_d, acc_lo_d} = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif
                    end else begin
                        acc_lo_d = abs_a;
                        mcand_d  = abs_b;
                    end
                end else begin
                    if (mthi) hi_d = op_a;
                    if (mtlo) lo_d = op_a;
                end
            end
            RUN: begin
                if (count_q != '0) count_d = count_q - 1'b1;
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div_zero_q) begin
                    lo_d = '1;
                    hi_d = raw_a_q;
                end else begin
                    lo_d = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                    hi_d = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed test-plan vectors plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

`ifdef HILO_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         mul;
    logic         div;
    logic         is_unsigned;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;
    logic [2*W-1:0] exp_q[$];

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .mul(mul), .div(div), .is_unsigned(is_unsigned),
        .mthi(mthi), .mtlo(mtlo), .op_a(op_a), .op_b(op_b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain integer arithmetic (truncating division).
    function automatic logic [2*W-1:0] ref_result(input bit is_mul, input bit uns,
                                                  input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        logic [2*W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mul) begin
            if (uns) r = {32'b0, a} * {32'b0, b};
            else begin
                p = sa * sb;
                r = p;
            end
        end else if (b == 0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (uns) begin
            r = {a % b, a / b};
        end else begin
            r = {32'(sa % sb), 32'(sa / sb)};
        end
        return r;
    endfunction

    // Issues one op, follows it to done, checks latency, busy span, done width and HI/LO.
    // inject_at >= 0 drives a stray mul+mthi while busy at that cycle offset.
    task automatic run_op(input string name, input bit is_mul, input bit uns,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit with_mt, input int inject_at);
        int j, busy_n, exp_lat;
        logic [2*W-1:0] exp;
        exp_q.push_back(ref_result(is_mul, uns, a, b));
        exp_lat = (is_mul && FAST) ? 1 : W + 1;
        @(negedge clk);
        mul = is_mul; div = !is_mul; is_unsigned = uns; op_a = a; op_b = b;
        mthi = with_mt; mtlo = with_mt;
        @(negedge clk);
        mul = 0; div = 0; mthi = 0; mtlo = 0;
        checks++;
        if (hi !== model_hi || lo !== model_lo) begin
            errors++;
            $display("FAIL %s start_hold: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, model_hi, model_lo);
        end
        j = 0; busy_n = 0;
        while (done !== 1'b1 && j < 100) begin
            if (busy === 1'b1) busy_n++;
            mul  = (j == inject_at);
            mthi = (j == inject_at);
            op_a = (j == inject_at) ? 32'hDEAD_BEEF : a;
            @(negedge clk);
            j++;
        end
        mul = 0; mthi = 0; op_a = a;
        exp = exp_q.pop_front();
        checks++;
        if (j !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, j, exp_lat);
        end
        checks++;
        if (busy_n !== exp_lat || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: high %0d cycles (busy now %b), expected %0d then 0", name, busy_n, busy, exp_lat);
        end
        checks++;
        if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
        end
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b hi=%h lo=%h, expected done=0 hi=%h lo=%h", name, done, hi, lo, model_hi, model_lo);
        end
    endtask

    task automatic test_reset;
        reset = 1; mul = 0; div = 0; is_unsigned = 0; mthi = 0; mtlo = 0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        checks++;
        if (hi !== 0 || lo !== 0 || done !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h done=%b busy=%b expected all zero", hi, lo, done, busy);
        end
    endtask

    task automatic test_directed;
        run_op("multu_max", 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1);
        run_op("mult_neg",  1, 0, 32'hFFFF_FFFD, 32'd7, 0, -1);
        run_op("mult_6x7",  1, 0, 32'd6, 32'd7, 0, -1);
        run_op("divu_7_2",  0, 1, 32'd7, 32'd2, 0, -1);
        run_op("div_neg7_2", 0, 0, 32'hFFFF_FFF9, 32'd2, 0, -1);
        run_op("div_ovf",   0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1);
        run_op("div_zero",  0, 0, 32'h0000_1234, 32'd0, 0, -1);
        run_op("div_zero_neg", 0, 0, 32'h8000_0001, 32'd0, 0, -1);
        run_op("start_with_mt", 0, 1, 32'd100, 32'd9, 1, -1);
    endtask

    task automatic mt_write(input string name, input bit h, input bit l, input logic [W-1:0] v);
        @(negedge clk);
        mthi = h; mtlo = l; op_a = v;
        @(negedge clk);
        mthi = 0; mtlo = 0;
        if (h) model_hi = v;
        if (l) model_lo = v;
        checks++;
        if (hi !== model_hi || lo !== model_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", name, hi, lo, busy, model_hi, model_lo);
        end
    endtask

    task automatic test_mt;
        mt_write("mthi_aa", 1, 0, 32'h0000_00AA);
        mt_write("mtlo_55", 0, 1, 32'h0000_0055);
        mt_write("mt_both", 1, 1, 32'h1357_9BDF);
    endtask

    task automatic test_both_strobes;
        @(negedge clk);
        mul = 1; div = 1; mthi = 1; op_a = 32'h77;
        @(negedge clk);
        mul = 0; div = 0; mthi = 0;
        model_hi = 32'h77;
        checks++;
        if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            errors++;
            $display("FAIL both_strobes: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, model_hi, model_lo);
        end
    endtask

    task automatic test_busy_ignore;
        run_op("busy_ignore_div", 0, 0, 32'hFFFF_FF00, 32'd13, 0, 5);
        run_op("busy_ignore_late", 0, 1, 32'hCAFE_F00D, 32'd3, 0, 31);
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        div = 1; is_unsigned = 0; op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        div = 0;
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_hi = '0; model_lo = '0;
        checks++;
        if (busy !== 1'b0 || hi !== 0 || lo !== 0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || hi !== 0 || lo !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: done/busy seen %0d cycles, hi=%h lo=%h expected none and zero", seen, hi, lo);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random;
        logic [W-1:0] a, b;
        bit m, u;
        for (int i = 0; i < 30; i++) begin
            m = $urandom_range(0, 1);
            u = $urandom_range(0, 1);
            a = pick_operand();
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : pick_operand();
            run_op($sformatf("rand%0d", i), m, u, a, b, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_both_strobes();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
